// File: rtl/tail_light_pkg.sv
// Shared types and constants for the tail-light lamp monitor: group tracker states,
// mode codes, group classes and the 7-segment code table.
package tail_light_pkg;

  typedef logic [2:0] group_state_t;

  localparam group_state_t G_OFF = 3'd0;
  localparam group_state_t G_B1  = 3'd1;
  localparam group_state_t G_B2  = 3'd2;
  localparam group_state_t G_B3  = 3'd3;
  localparam group_state_t G_ON  = 3'd4;

  localparam logic [2:0] MODE_IDLE        = 3'd0;
  localparam logic [2:0] MODE_LEFT        = 3'd1;
  localparam logic [2:0] MODE_RIGHT       = 3'd2;
  localparam logic [2:0] MODE_BRAKE       = 3'd3;
  localparam logic [2:0] MODE_LEFT_BRAKE  = 3'd4;
  localparam logic [2:0] MODE_RIGHT_BRAKE = 3'd5;
  localparam logic [2:0] MODE_HAZARD      = 3'd6;
  localparam logic [2:0] MODE_FAULT       = 3'd7;

  typedef enum logic [1:0] {
    CLS_OFF,
    CLS_SEQ,
    CLS_ON
  } group_class_t;

  // Active-low segments, dp (bit 7) always off.
  function automatic logic [7:0] seg_code(input logic [2:0] mode);
    logic [7:0] code;
    case (mode)
      MODE_IDLE:        code = 8'hC0;
      MODE_LEFT:        code = 8'hF9;
      MODE_RIGHT:       code = 8'hA4;
      MODE_BRAKE:       code = 8'hB0;
      MODE_LEFT_BRAKE:  code = 8'h99;
      MODE_RIGHT_BRAKE: code = 8'h92;
      MODE_HAZARD:      code = 8'h82;
      default:          code = 8'h8E;
    endcase
    return code;
  endfunction

  function automatic group_class_t classify(input group_state_t st, input logic seq);
    group_class_t cls;
    if (seq || st == G_B1 || st == G_B2 || st == G_B3) begin
      cls = CLS_SEQ;
    end else if (st == G_ON) begin
      cls = CLS_ON;
    end else begin
      cls = CLS_OFF;
    end
    return cls;
  endfunction

endpackage

// File: rtl/tail_light_decoder_if.sv
// Lamp-image input and decoded-status outputs of the tail-light monitor.
interface tail_light_decoder_if #(
  parameter int unsigned FCNT_W = 8
);
  logic              tick;
  logic [9:0]        lamps;
  logic [2:0]        mode;
  logic              mode_valid;
  logic              fault;
  logic [FCNT_W-1:0] fault_count;
  logic [7:0]        hex;

  modport master (
    output tick, lamps,
    input  mode, mode_valid, fault, fault_count, hex
  );

  modport slave (
    input  tick, lamps,
    output mode, mode_valid, fault, fault_count, hex
  );
endinterface

// File: rtl/lamp_group_tracker.sv
// Follows one three-lamp group ({inner,mid,outer}) tick by tick, reporting its state,
// whether it is still sequencing, and whether the last sampled step was illegal.
module lamp_group_tracker
  import tail_light_pkg::*;
#(
  parameter int unsigned SEQ_TIMEOUT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  logic [2:0]   pattern,
  output group_state_t state,
  output logic         seq,
  output logic         illegal
);

  localparam int unsigned CNT_W = $clog2(SEQ_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SEQ_TIMEOUT);

  group_state_t     state_q, state_d;
  logic             seq_q, seq_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = G_OFF;
    seq_d     = seq_q;
    illegal_d = 1'b0;
    case (pattern)
      3'b000: begin
        if (state_q == G_B3) seq_d = 1'b1;
      end
      3'b100: begin
        state_d   = G_B1;
        illegal_d = (state_q != G_OFF);
      end
      3'b110: begin
        if (state_q == G_B1) state_d = G_B2;
        else illegal_d = 1'b1;
      end
      3'b111: begin
        if (state_q == G_B2) begin
          state_d = G_B3;
        end else begin
          // Full pattern outside a sweep means steady-on; only a skip from B1 is wrong.
          state_d   = G_ON;
          seq_d     = 1'b0;
          illegal_d = (state_q == G_B1);
        end
      end
      default: illegal_d = 1'b1;
    endcase
    if (illegal_d) seq_d = 1'b0;

    if (state_d == G_B1) cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else cnt_d = cnt_q + CNT_W'(1);
    if (cnt_d == CNT_MAX) seq_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= G_OFF;
      seq_q     <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else if (tick) begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state   = state_q;
  assign seq     = seq_q;
  assign illegal = illegal_q;

endmodule

// File: rtl/tail_light_decoder.sv
// Tail-light lamp monitor: classifies the two lamp groups into a mode, flags faults and
// drives a 7-seg digit. Define HAZARD_PHASE_CHECK_EN to require lock-step groups in HAZARD.
module tail_light_decoder
  import tail_light_pkg::*;
#(
  parameter int unsigned SEQ_TIMEOUT = 4,
  parameter int unsigned FCNT_W      = 8
) (
  input logic                 clock,
  input logic                 reset,
  tail_light_decoder_if.slave bus
);

  group_state_t l_state, r_state;
  logic         l_seq, r_seq, l_ill, r_ill;
  group_class_t l_cls, r_cls;

  logic              tick_q, pad_err_q;
  logic [2:0]        mode_q, mode_raw, mode_d;
  logic              mode_valid_q, valid_d;
  logic              fault_q, tick_fault, phase_err;
  logic [FCNT_W-1:0] fcnt_q;
  logic [7:0]        hex_q;
  logic [1:0]        vcnt_q, vcnt_d;

  lamp_group_tracker #(.SEQ_TIMEOUT(SEQ_TIMEOUT)) u_left (
    .clock   (clock),
    .reset   (reset),
    .tick    (bus.tick),
    .pattern ({bus.lamps[7], bus.lamps[8], bus.lamps[9]}),
    .state   (l_state),
    .seq     (l_seq),
    .illegal (l_ill)
  );

  lamp_group_tracker #(.SEQ_TIMEOUT(SEQ_TIMEOUT)) u_right (
    .clock   (clock),
    .reset   (reset),
    .tick    (bus.tick),
    .pattern ({bus.lamps[2], bus.lamps[1], bus.lamps[0]}),
    .state   (r_state),
    .seq     (r_seq),
    .illegal (r_ill)
  );

  always_comb begin
    l_cls    = classify(l_state, l_seq);
    r_cls    = classify(r_state, r_seq);
    mode_raw = MODE_FAULT;
    case ({l_cls, r_cls})
      {CLS_OFF, CLS_OFF}: mode_raw = MODE_IDLE;
      {CLS_SEQ, CLS_OFF}: mode_raw = MODE_LEFT;
      {CLS_OFF, CLS_SEQ}: mode_raw = MODE_RIGHT;
      {CLS_ON,  CLS_ON }: mode_raw = MODE_BRAKE;
      {CLS_SEQ, CLS_ON }: mode_raw = MODE_LEFT_BRAKE;
      {CLS_ON,  CLS_SEQ}: mode_raw = MODE_RIGHT_BRAKE;
      {CLS_SEQ, CLS_SEQ}: mode_raw = MODE_HAZARD;
      default:            mode_raw = MODE_FAULT;
    endcase

`ifdef HAZARD_PHASE_CHECK_EN
    phase_err = (mode_raw == MODE_HAZARD) && (l_state != r_state);
`else
    phase_err = 1'b0;
`endif

    tick_fault = l_ill || r_ill || pad_err_q || phase_err || (mode_raw == MODE_FAULT);
    mode_d     = tick_fault ? MODE_FAULT : mode_raw;
    vcnt_d     = (vcnt_q == 2'd2) ? vcnt_q : vcnt_q + 2'd1;
    valid_d    = (vcnt_d == 2'd2);
  end

  // Trackers update on the tick edge; everything below follows one clock later.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_q       <= 1'b0;
      pad_err_q    <= 1'b0;
      mode_q       <= MODE_IDLE;
      mode_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      fcnt_q       <= '0;
      hex_q        <= 8'hFF;
      vcnt_q       <= 2'd0;
    end else begin
      tick_q    <= bus.tick;
      pad_err_q <= bus.tick && (bus.lamps[6:3] != 4'b0000);
      if (tick_q) begin
        mode_q       <= mode_d;
        mode_valid_q <= valid_d;
        vcnt_q       <= vcnt_d;
        hex_q        <= valid_d ? seg_code(mode_d) : 8'hFF;
        if (tick_fault) begin
          fault_q <= 1'b1;
          if (fcnt_q != '1) fcnt_q <= fcnt_q + FCNT_W'(1);
        end
      end
    end
  end

  assign bus.mode        = mode_q;
  assign bus.mode_valid  = mode_valid_q;
  assign bus.fault       = fault_q;
  assign bus.fault_count = fcnt_q;
  assign bus.hex         = hex_q;

endmodule

// File: tb/tb_tail_light_decoder.sv
// Bench for tail_light_decoder: directed vector table, reset/saturation sequences and
// randomized lamp images checked against a behavioural model.
module tb_tail_light_decoder;

  localparam int FW = 8;
`ifdef HAZARD_PHASE_CHECK_EN
  localparam bit PH = 1'b1;
`else
  localparam bit PH = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tail_light_decoder_if #(.FCNT_W(FW)) bus ();

  tail_light_decoder #(.SEQ_TIMEOUT(4), .FCNT_W(FW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit         rst;
    logic [9:0] lamps;
    int         mode;
    int         valid;
    int         fault;
    int         fcnt;
    int         hex;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int seg [8] = '{'hC0, 'hF9, 'hA4, 'hB0, 'h99, 'h92, 'h82, 'h8E};
  // [left class][right class], class 0 = off, 1 = sequencing, 2 = steady on
  int mode_tbl [3][3] = '{'{0, 2, 7}, '{1, 6, 4}, '{7, 5, 3}};

  // Model: stage 0 = dark, 1..3 = lamps lit in the sweep, 4 = steady on.
  int m_stg [2];
  int m_seq [2];
  int m_age [2];
  int m_ticks, m_fcnt, m_flt;
  int cyc [2];
  bit hz;

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int m, input int v, input int f,
                           input int c, input int h);
    cmp($sformatf("%s.mode", tag), int'(bus.mode), m);
    cmp($sformatf("%s.mode_valid", tag), int'(bus.mode_valid), v);
    cmp($sformatf("%s.fault", tag), int'(bus.fault), f);
    cmp($sformatf("%s.fault_count", tag), int'(bus.fault_count), c);
    cmp($sformatf("%s.hex", tag), int'(bus.hex), h);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    bus.tick = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One tick, then one idle cycle with junk on lamps; outputs are settled afterwards.
  task automatic apply_tick(input logic [9:0] l);
    @(negedge clock);
    bus.tick  = 1'b1;
    bus.lamps = l;
    @(negedge clock);
    bus.tick  = 1'b0;
    bus.lamps = ~l;
    @(negedge clock);
  endtask

  function automatic logic [2:0] therm(input int n);
    logic [2:0] t;
    t = 3'b111 << (3 - n);
    return t;
  endfunction

  function automatic int therm_n(input logic [2:0] p);
    int r;
    r = -1;
    for (int n = 0; n < 4; n++) if (p == therm(n)) r = n;
    return r;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_stg[g] = 0;
      m_seq[g] = 0;
      m_age[g] = 0;
    end
    m_ticks = 0;
    m_fcnt  = 0;
    m_flt   = 0;
  endtask

  task automatic model_group(input int g, input logic [2:0] p, output bit ill);
    int n, prev, nx;
    n    = therm_n(p);
    prev = m_stg[g];
    ill  = 1'b0;
    nx   = n;
    if (n < 0) begin
      ill = 1'b1;
      nx  = 0;
    end else if (n == 0) begin
      if (prev == 3) m_seq[g] = 1;
    end else if (n == 3 && prev != 2) begin
      nx       = 4;
      m_seq[g] = 0;
      ill      = (prev == 1);
    end else if (prev != n - 1) begin
      ill = 1'b1;
      nx  = (n == 1) ? 1 : 0;
    end
    if (ill) m_seq[g] = 0;
    m_age[g] = (nx == 1) ? 0 : ((m_age[g] < 4) ? m_age[g] + 1 : 4);
    if (m_age[g] >= 4) m_seq[g] = 0;
    m_stg[g] = nx;
  endtask

  function automatic int grp_class(input int g);
    int c;
    if (m_seq[g] != 0 || (m_stg[g] >= 1 && m_stg[g] <= 3)) c = 1;
    else if (m_stg[g] == 4) c = 2;
    else c = 0;
    return c;
  endfunction

  task automatic model_tick(input logic [9:0] l, output int m, output int v, output int f,
                            output int c, output int h);
    bit il, ir;
    model_group(0, {l[7], l[8], l[9]}, il);
    model_group(1, {l[2], l[1], l[0]}, ir);
    m = mode_tbl[grp_class(0)][grp_class(1)];
    if (PH && m == 6 && m_stg[0] != m_stg[1]) m = 7;
    if (il || ir || l[6:3] != 4'b0) m = 7;
    m_ticks++;
    if (m == 7) begin
      m_flt  = 1;
      m_fcnt = (m_fcnt < 255) ? m_fcnt + 1 : 255;
    end
    v = (m_ticks >= 2) ? 1 : 0;
    f = m_flt;
    c = m_fcnt;
    h = (v != 0) ? seg[m] : 'hFF;
  endtask

  initial begin
    vec_t       tbl[$];
    logic [9:0] l;
    logic [2:0] pat [2];
    int         r, em, ev, ef, ec, eh;

    bus.tick  = 1'b0;
    bus.lamps = '0;
    hz        = 1'b0;
    cyc[0]    = 0;
    cyc[1]    = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_all("reset", 0, 0, 0, 0, 'hFF);

    // Left sweep, steady brake, left sweep over brake then timeout into OFF/ON.
    tbl.push_back('{1'b0, 10'h000, 0, 0, 0, 0, 'hFF});
    tbl.push_back('{1'b0, 10'h080, 1, 1, 0, 0, 'hF9});
    tbl.push_back('{1'b0, 10'h180, 1, 1, 0, 0, 'hF9});
    tbl.push_back('{1'b0, 10'h380, 1, 1, 0, 0, 'hF9});
    tbl.push_back('{1'b0, 10'h000, 1, 1, 0, 0, 'hF9});
    tbl.push_back('{1'b0, 10'h080, 1, 1, 0, 0, 'hF9});
    tbl.push_back('{1'b0, 10'h180, 1, 1, 0, 0, 'hF9});
    tbl.push_back('{1'b0, 10'h380, 1, 1, 0, 0, 'hF9});
    tbl.push_back('{1'b0, 10'h000, 1, 1, 0, 0, 'hF9});
    tbl.push_back('{1'b0, 10'h387, 3, 1, 0, 0, 'hB0});
    tbl.push_back('{1'b0, 10'h387, 3, 1, 0, 0, 'hB0});
    tbl.push_back('{1'b0, 10'h387, 3, 1, 0, 0, 'hB0});
    tbl.push_back('{1'b0, 10'h000, 0, 1, 0, 0, 'hC0});
    tbl.push_back('{1'b0, 10'h087, 4, 1, 0, 0, 'h99});
    tbl.push_back('{1'b0, 10'h187, 4, 1, 0, 0, 'h99});
    tbl.push_back('{1'b0, 10'h387, 4, 1, 0, 0, 'h99});
    tbl.push_back('{1'b0, 10'h007, 4, 1, 0, 0, 'h99});
    tbl.push_back('{1'b0, 10'h007, 7, 1, 1, 1, 'h8E});
    tbl.push_back('{1'b0, 10'h007, 7, 1, 1, 2, 'h8E});
    tbl.push_back('{1'b0, 10'h007, 7, 1, 1, 3, 'h8E});
    // Skipped step 100 -> 111; fault stays sticky after recovery.
    tbl.push_back('{1'b1, 10'h000, 0, 0, 0, 0, 'hFF});
    tbl.push_back('{1'b0, 10'h080, 1, 1, 0, 0, 'hF9});
    tbl.push_back('{1'b0, 10'h380, 7, 1, 1, 1, 'h8E});
    tbl.push_back('{1'b0, 10'h000, 0, 1, 1, 1, 'hC0});
    tbl.push_back('{1'b0, 10'h080, 1, 1, 1, 1, 'hF9});
    // Hazard with the right group one step behind.
    tbl.push_back('{1'b1, 10'h000, 0, 0, 0, 0, 'hFF});
    tbl.push_back('{1'b0, 10'h080, 1, 1, 0, 0, 'hF9});
    tbl.push_back('{1'b0, 10'h184, PH ? 7 : 6, 1, int'(PH), PH ? 1 : 0, PH ? 'h8E : 'h82});
    tbl.push_back('{1'b0, 10'h386, PH ? 7 : 6, 1, int'(PH), PH ? 2 : 0, PH ? 'h8E : 'h82});
    tbl.push_back('{1'b0, 10'h007, PH ? 7 : 6, 1, int'(PH), PH ? 3 : 0, PH ? 'h8E : 'h82});
    tbl.push_back('{1'b0, 10'h080, PH ? 7 : 6, 1, int'(PH), PH ? 4 : 0, PH ? 'h8E : 'h82});

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      apply_tick(tbl[i].lamps);
      check_all($sformatf("vec%0d", i), tbl[i].mode, tbl[i].valid, tbl[i].fault,
                tbl[i].fcnt, tbl[i].hex);
    end

    // Reset arriving together with a tick mid-sweep.
    do_reset();
    apply_tick(10'h080);
    apply_tick(10'h180);
    @(negedge clock);
    reset     = 1'b1;
    bus.tick  = 1'b1;
    bus.lamps = 10'h380;
    @(negedge clock);
    reset    = 1'b0;
    bus.tick = 1'b0;
    @(negedge clock);
    check_all("rst_tick", 0, 0, 0, 0, 'hFF);
    apply_tick(10'h010);
    check_all("pad_bit", 7, 0, 1, 1, 'hFF);
    repeat (299) apply_tick(10'h010);
    check_all("fcnt_sat", 7, 1, 1, 255, 'h8E);

    // Randomized lamp images against the model.
    do_reset();
    model_reset();
    for (int i = 0; i < 500; i++) begin
      for (int g = 0; g < 2; g++) begin
        r = $urandom_range(0, 9);
        if (r < 7) cyc[g] = (cyc[g] + 1) % 4;
        else if (r == 7) cyc[g] = 3;
        else if (r == 8) cyc[g] = 0;
        pat[g] = (r == 9) ? 3'($urandom_range(0, 7)) : therm(cyc[g]);
      end
      if (hz) pat[1] = pat[0];
      if ($urandom_range(0, 19) == 0) hz = !hz;
      l = {pat[0][0], pat[0][1], pat[0][2], 4'b0000, pat[1]};
      if ($urandom_range(0, 24) == 0) l[3 + $urandom_range(0, 3)] = 1'b1;
      apply_tick(l);
      model_tick(l, em, ev, ef, ec, eh);
      check_all($sformatf("rnd%0d", i), em, ev, ef, ec, eh);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
